load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts byte-addressed load/store requests from the pipeline over a valid/ready handshake.
- Drives word-wide memory control: address, write data, write enable, read enable.
- Performs byte/halfword extraction with sign/zero extension on loads; performs read-modify-write for sub-word stores.
- Checks alignment and range; returns one response per accepted request.

Parameters:
- DATA_W, 32, memory word width; fixed 4 byte lanes.
- ADDR_W, 5, memory word-address width.
- DEPTH, 32, number of implemented words; word addresses >= DEPTH are errors.
- MEM_LAT, 1, memory read latency in cycles (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  sign-extend loads.
- req_addr  in  ADDR_W+2  byte address; [1:0] lane offset.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  1  misaligned, out-of-range or illegal size; qualifies rsp_valid.
- rsp_data  out  DATA_W  load result; 0 for stores and errors.
- mem_addr  out  ADDR_W  word address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_we  out  1  write enable, one cycle per write.
- mem_re  out  1  read enable.
- mem_rdata  in  DATA_W  read data from memory.

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset: state IDLE. mem_we=0, mem_re=0, rsp_valid=0, rsp_err=0. rsp_data, mem_addr and mem_wdata are 0. Assertion mid-operation drops the in-flight request immediately; no response is issued and mem_we falls asynchronously.
- All memory-side outputs and rsp_valid/rsp_err are Moore outputs, decoded from state and latched request registers only.
- Handshake: req_ready=1 only in IDLE. A request is accepted on an edge with req_valid&&req_ready; req_* are latched at that edge and ignored otherwise.
- Error check at accept, with no memory access on error:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[ADDR_W+1:2] >= DEPTH.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE -> RESP on error.
  - IDLE -> WRITE on word store.
  - IDLE -> READ on load or sub-word store.
  - READ: mem_re=1, mem_addr=word addr, held MEM_LAT cycles (counter). mem_rdata is sampled at the edge ending the last READ cycle.
    - Load: extract lane, extend, register into rsp_data, go to RESP.
    - Sub-word store: merge req_wdata low bytes into the sampled word at the addressed lanes, register into mem_wdata, go to WRITE.
  - WRITE: mem_we=1 for exactly one cycle, then RESP.
  - RESP: rsp_valid=1 for one cycle, rsp_err per check, then IDLE.
- Lane rules: little-endian; byte k = data[8k+7:8k]; halfword at offset 0 or 2. Loads extend from bit 7 (byte) or bit 15 (half) when req_signed=1, otherwise zero-extend. Word loads ignore req_signed.
- Latency from accept edge, with MEM_LAT=1: error 1 cycle; word store 2; load 2; sub-word store 3. Each READ cycle beyond MEM_LAT=1 adds one cycle.
- rsp_data holds its value until the next response; it is forced to 0 on store or error responses.
- Back-to-back: a new request may be accepted on the edge leaving RESP. There is no response backpressure.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - FSM state enum;
  - lane-count constant.
- Sub-module lsu_lane_align, combinational:
  - load extract/extend from word, offset, size and signed;
  - store merge from old word, new data, offset and size.
- The FSM and handshake stay in load_store_unit.

Test Plan:
- Word store addr=0x08, wdata=0xDEADBEEF, then word load addr=0x08:
  - store: mem_we one cycle with mem_addr=2, mem_wdata=0xDEADBEEF; rsp_valid 2 cycles after accept.
  - load: rsp_data=0xDEADBEEF, rsp_err=0.
- Byte loads from word 2=0xDEADBEEF, addr=0x0A:
  - signed: rsp_data=0xFFFFFFAD.
  - unsigned: rsp_data=0x000000AD.
- Byte store addr=0x09, wdata=0x11 into 0xDEADBEEF:
  - READ, then mem_wdata=0xDEAD11EF with mem_we; rsp 3 cycles after accept.
- Error cases, each giving rsp_err=1, rsp_data=0 one cycle after accept, with mem_we and mem_re never asserted:
  - half load addr=0x03;
  - word store addr=0x06;
  - req_size=11;
  - DEPTH=4 with word load addr=0x10.
- rst_n low during WRITE:
  - mem_we drops asynchronously;
  - no rsp_valid;
  - req_ready=1 after release;
  - memory word unchanged if rst_n falls before the WRITE edge.
- req_valid held with changing req_addr while busy: only the value at the accept edge is used. A second request is accepted on the edge leaving RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// lane geometry and the alignment rule used at request accept.
package lsu_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned WORD_W = LANES * BYTE_W;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_BAD  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } state_e;

   // Illegal size counts as misaligned so one call covers both checks.
   function automatic logic size_misaligned(input size_e sz, input logic [1:0] off);
      logic bad;
      case (sz)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus word-wide data-memory bus of the LSU.
// slave = the load/store unit itself, master = the pipeline/memory environment.
interface load_store_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W+1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_err;
   logic [DATA_W-1:0] rsp_data;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  mem_rdata,
      output req_ready, rsp_valid, rsp_err, rsp_data,
      output mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output mem_rdata,
      input  req_ready, rsp_valid, rsp_err, rsp_data,
      input  mem_addr, mem_wdata, mem_we, mem_re
   );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract with sign/zero extension, and the
// byte-lane merge used for read-modify-write of sub-word stores (little-endian).
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   input  logic [WORD_W-1:0] i_new,
   input  logic [1:0]        i_off,
   input  size_e             i_size,
   input  logic              i_signed,
   output logic [WORD_W-1:0] o_load,
   output logic [WORD_W-1:0] o_merge
);

   logic [WORD_W-1:0] w_shifted;
   logic [WORD_W-1:0] w_new_sh;
   logic [LANES-1:0]  w_be;
   logic              w_sign;

   always_comb begin
      w_shifted = i_word >> {i_off, 3'b000};
      w_sign    = 1'b0;
      o_load    = i_word;
      case (i_size)
         SZ_BYTE: begin
            w_sign = i_signed & w_shifted[7];
            o_load = {{(WORD_W-8){w_sign}}, w_shifted[7:0]};
         end
         SZ_HALF: begin
            w_sign = i_signed & w_shifted[15];
            o_load = {{(WORD_W-16){w_sign}}, w_shifted[15:0]};
         end
         default: o_load = i_word;
      endcase
   end

   // New data is right-justified; shift it onto the addressed lanes, then pick per lane.
   always_comb begin
      w_new_sh = i_new << {i_off, 3'b000};
      case (i_size)
         SZ_BYTE: w_be = 4'b0001 << i_off;
         SZ_HALF: w_be = 4'b0011 << i_off;
         default: w_be = 4'b1111;
      endcase
      o_merge = i_word;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (w_be[k]) begin
            o_merge[BYTE_W*k +: BYTE_W] = w_new_sh[BYTE_W*k +: BYTE_W];
         end
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte-addressed requests, checks alignment/range, drives a
// word-wide memory and returns one response per request (RMW for sub-word stores).
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DEPTH   = 32,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   load_store_unit_if.slave bus
);

   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   state_e            r_state;
   state_e            w_state_nxt;

   logic              r_write;
   size_e             r_size;
   logic              r_signed;
   logic [1:0]        r_off;
   logic [ADDR_W-1:0] r_waddr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_err;
   logic [CNT_W-1:0]  r_lat_cnt;

   size_e             w_req_size;
   logic [ADDR_W-1:0] w_req_word;
   logic              w_accept;
   logic              w_err;
   logic              w_word_store;
   logic              w_rd_last;
   logic [DATA_W-1:0] w_load;
   logic [DATA_W-1:0] w_merge;

   assign w_req_size   = size_e'(bus.req_size);
   assign w_req_word   = bus.req_addr[ADDR_W+1:2];
   assign w_accept     = bus.req_valid && (r_state == IDLE);
   assign w_err        = size_misaligned(w_req_size, bus.req_addr[1:0])
                         || (32'(w_req_word) >= DEPTH);
   assign w_word_store = bus.req_write && (w_req_size == SZ_WORD);
   assign w_rd_last    = (r_lat_cnt == CNT_W'(MEM_LAT - 1));

   lsu_lane_align u_align (
      .i_word   (bus.mem_rdata),
      .i_new    (r_wdata),
      .i_off    (r_off),
      .i_size   (r_size),
      .i_signed (r_signed),
      .o_load   (w_load),
      .o_merge  (w_merge)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      bus.req_ready = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_err   = 1'b0;
      case (r_state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (w_accept) begin
               if (w_err) begin
                  w_state_nxt = RESP;
               end else if (w_word_store) begin
                  w_state_nxt = WRITE;
               end else begin
                  w_state_nxt = READ;
               end
            end
         end
         READ: begin
            bus.mem_re = 1'b1;
            if (w_rd_last) begin
               w_state_nxt = r_write ? WRITE : RESP;
            end
         end
         WRITE: begin
            bus.mem_we  = 1'b1;
            w_state_nxt = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = r_err;
            w_state_nxt   = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // rsp_data only changes when a response is being formed, so it holds between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write     <= 1'b0;
         r_size      <= SZ_BYTE;
         r_signed    <= 1'b0;
         r_off       <= '0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_mem_wdata <= '0;
         r_rsp_data  <= '0;
         r_err       <= 1'b0;
         r_lat_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_write   <= bus.req_write;
            r_size    <= w_req_size;
            r_signed  <= bus.req_signed;
            r_off     <= bus.req_addr[1:0];
            r_waddr   <= w_req_word;
            r_wdata   <= bus.req_wdata;
            r_err     <= w_err;
            r_lat_cnt <= '0;
            if (w_err) begin
               r_rsp_data <= '0;
            end else if (w_word_store) begin
               r_mem_wdata <= bus.req_wdata;
            end
         end
         if (r_state == READ) begin
            if (w_rd_last) begin
               if (r_write) begin
                  r_mem_wdata <= w_merge;
               end else begin
                  r_rsp_data <= w_load;
               end
            end else begin
               r_lat_cnt <= r_lat_cnt + CNT_W'(1);
            end
         end
         if (r_state == WRITE) begin
            r_rsp_data <= '0;
         end
      end
   end

   assign bus.mem_addr  = r_waddr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.rsp_data  = r_rsp_data;

endmodule
